// File: rtl/money_pkg.sv
// money_pkg: shared types and constants for the money spawn-slot scheduler.
//   round_state_t : round FSM encoding (IDLE=0, STAGGER=1, ACTIVE=2, ENDED=3)
//   SPAWN_X_*     : spawn X position of slot k is SPAWN_X_BASE + k*SPAWN_X_PITCH
//   LFSR_*        : seed and Galois taps of the respawn random source
//   SCORE_MAX     : saturation value of a banked score
package money_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STAGGER = 2'd1,
    ACTIVE  = 2'd2,
    ENDED   = 2'd3
  } round_state_t;

  localparam logic [9:0]  SPAWN_X_BASE  = 10'd40;
  localparam logic [9:0]  SPAWN_X_PITCH = 10'd140;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [7:0]  SCORE_MAX     = 8'd255;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (right-shifting, taps LFSR_TAPS), free-running one step per frame.
//   FrameClk : frame clock
//   Reset    : asynchronous active-high reset, loads LFSR_SEED
//   Q        : current LFSR state
module lfsr16
  import money_pkg::*;
(
  input  logic        FrameClk,
  input  logic        Reset,
  output logic [15:0] Q
);

  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, Q[15:1]};
    if (Q[0]) begin
      q_d = q_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      Q <= LFSR_SEED;
    end else begin
      Q <= q_d;
    end
  end

endmodule

// File: rtl/money_bag.sv
// money_bag: one player's bag and banked score.
//   frame_clk_i : frame clock
//   reset_i     : asynchronous active-high reset
//   clear_i     : round start, zeroes bag and score
//   update_i    : bag/score may change this frame (round live, no start/stop pulse)
//   deposit_i   : player on the bank tile
//   collect_i   : 2-bit collect value per slot, slot k at [2k+1:2k]
//   bag_o       : bag contents, saturating at BAG_CAP
//   score_o     : banked score, saturating at SCORE_MAX
//   full_o      : bag at or above capacity (from the registered bag only)
module money_bag
  import money_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned BAG_CAP   = 6
) (
  input  logic                   frame_clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   update_i,
  input  logic                   deposit_i,
  input  logic [2*NUM_SLOTS-1:0] collect_i,
  output logic [3:0]             bag_o,
  output logic [7:0]             score_o,
  output logic                   full_o
);

  localparam logic [5:0] BagCap = 6'(BAG_CAP);

  logic [3:0] bag_q, bag_d;
  logic [7:0] score_q, score_d;
  logic [5:0] sum;
  logic [8:0] score_sum;

  // A deposit banks the old bag; this frame's collects start the fresh bag.
  always_comb begin
    sum = deposit_i ? 6'd0 : {2'b00, bag_q};
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      sum = sum + {4'b0000, collect_i[2*k +: 2]};
    end
    bag_d     = (sum > BagCap) ? BagCap[3:0] : sum[3:0];
    score_sum = {1'b0, score_q} + {5'b00000, bag_q};
    score_d   = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[7:0];
  end

  always_ff @(posedge frame_clk_i or posedge reset_i) begin
    if (reset_i) begin
      bag_q   <= 4'd0;
      score_q <= 8'd0;
    end else if (clear_i) begin
      bag_q   <= 4'd0;
      score_q <= 8'd0;
    end else if (update_i) begin
      bag_q <= bag_d;
      if (deposit_i) begin
        score_q <= score_d;
      end
    end
  end

  assign bag_o   = bag_q;
  assign score_o = score_q;
  assign full_o  = (bag_q >= BagCap[3:0]);

endmodule

// File: rtl/money_scheduler.sv
// money_scheduler: round-level controller for the money spawn slots.
// Sequences slot enables, supplies constant spawn X positions and LFSR respawn seeds,
// tallies collects into per-player bags and banks bags into scores on deposit.
// Build option: define MONEY_STAGGER_EN to bring slots up one at a time (STAGGER state);
// otherwise RoundStart enables every slot at once and STAGGER stays an unused encoding.
//   FrameClk / Reset           : frame clock, asynchronous active-high reset
//   RoundStart / RoundStop     : single-frame round control pulses (start wins)
//   P1CollectVec/P2CollectVec  : per-slot 2-bit collect values, slot k at [2k+1:2k]
//   P1Deposit / P2Deposit      : player standing on the bank tile
//   SpawnEnable                : per-slot enable (registered)
//   SpawnX                     : slot k X position at [10k+9:10k]
//   Random                     : slot k seed at [3k+2:3k]
//   P1Full/P2Full, P1Bag/P2Bag : bag back-pressure and contents
//   P1Score/P2Score            : banked scores
//   RoundState                 : current FSM state
module money_scheduler
  import money_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned BAG_CAP        = 6,
  parameter int unsigned STAGGER_FRAMES = 30
) (
  input  logic                    FrameClk,
  input  logic                    Reset,
  input  logic                    RoundStart,
  input  logic                    RoundStop,
  input  logic [2*NUM_SLOTS-1:0]  P1CollectVec,
  input  logic [2*NUM_SLOTS-1:0]  P2CollectVec,
  input  logic                    P1Deposit,
  input  logic                    P2Deposit,
  output logic [NUM_SLOTS-1:0]    SpawnEnable,
  output logic [10*NUM_SLOTS-1:0] SpawnX,
  output logic [3*NUM_SLOTS-1:0]  Random,
  output logic                    P1Full,
  output logic                    P2Full,
  output logic [3:0]              P1Bag,
  output logic [3:0]              P2Bag,
  output logic [7:0]              P1Score,
  output logic [7:0]              P2Score,
  output logic [1:0]              RoundState
);

  localparam logic [NUM_SLOTS-1:0] AllOn = '1;

  round_state_t          state_q;
  logic [NUM_SLOTS-1:0]  spawn_en_q;
  logic                  live;
  logic                  update;
  logic [15:0]           lfsr_q;

`ifdef MONEY_STAGGER_EN
  localparam int unsigned StaggerLast = (NUM_SLOTS - 1) * STAGGER_FRAMES;
  localparam int unsigned CntW        = (StaggerLast > 1) ? $clog2(StaggerLast + 1) : 1;

  logic [CntW-1:0]      stagger_cnt_q;
  logic [CntW-1:0]      stagger_nxt;
  logic [NUM_SLOTS-1:0] stagger_en;

  // Enables are registered, so they are computed from the count the next frame will hold.
  always_comb begin
    stagger_nxt = stagger_cnt_q + 1'b1;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      stagger_en[k] = (32'(stagger_nxt) >= k * STAGGER_FRAMES);
    end
  end

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      spawn_en_q    <= '0;
      stagger_cnt_q <= '0;
    end else if (RoundStart) begin
      stagger_cnt_q <= '0;
      if (StaggerLast == 0) begin
        state_q    <= ACTIVE;
        spawn_en_q <= AllOn;
      end else begin
        state_q    <= STAGGER;
        spawn_en_q <= NUM_SLOTS'(1);
      end
    end else begin
      case (state_q)
        STAGGER: begin
          if (RoundStop) begin
            state_q    <= ENDED;
            spawn_en_q <= '0;
          end else begin
            stagger_cnt_q <= stagger_nxt;
            spawn_en_q    <= stagger_en;
            if (32'(stagger_nxt) == StaggerLast) begin
              state_q <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (RoundStop) begin
            state_q    <= ENDED;
            spawn_en_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign live = (state_q == STAGGER) || (state_q == ACTIVE);
`else
  logic unused_cfg;
  assign unused_cfg = ^STAGGER_FRAMES;

  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      spawn_en_q <= '0;
    end else if (RoundStart) begin
      state_q    <= ACTIVE;
      spawn_en_q <= AllOn;
    end else if (state_q == ACTIVE && RoundStop) begin
      state_q    <= ENDED;
      spawn_en_q <= '0;
    end
  end

  assign live = (state_q == ACTIVE);
`endif

  // A stop frame's collects and deposits are dropped; a start frame clears instead.
  assign update = live && !RoundStart && !RoundStop;

  lfsr16 u_lfsr (
    .FrameClk (FrameClk),
    .Reset    (Reset),
    .Q        (lfsr_q)
  );

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:3*NUM_SLOTS];
  assign Random      = lfsr_q[3*NUM_SLOTS-1:0];

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_spawn_x
    assign SpawnX[10*k +: 10] = SPAWN_X_BASE + 10'(k) * SPAWN_X_PITCH;
  end

  money_bag #(
    .NUM_SLOTS (NUM_SLOTS),
    .BAG_CAP   (BAG_CAP)
  ) u_bag_p1 (
    .frame_clk_i (FrameClk),
    .reset_i     (Reset),
    .clear_i     (RoundStart),
    .update_i    (update),
    .deposit_i   (P1Deposit),
    .collect_i   (P1CollectVec),
    .bag_o       (P1Bag),
    .score_o     (P1Score),
    .full_o      (P1Full)
  );

  money_bag #(
    .NUM_SLOTS (NUM_SLOTS),
    .BAG_CAP   (BAG_CAP)
  ) u_bag_p2 (
    .frame_clk_i (FrameClk),
    .reset_i     (Reset),
    .clear_i     (RoundStart),
    .update_i    (update),
    .deposit_i   (P2Deposit),
    .collect_i   (P2CollectVec),
    .bag_o       (P2Bag),
    .score_o     (P2Score),
    .full_o      (P2Full)
  );

  assign SpawnEnable = spawn_en_q;
  assign RoundState  = state_q;

endmodule

// File: tb/tb_money_scheduler.sv
// Testbench for money_scheduler (NUM_SLOTS=4, BAG_CAP=6, STAGGER_FRAMES=30).
module tb_money_scheduler;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] p1c;
    logic [7:0] p2c;
    logic       p1d;
    logic       p2d;
    logic       chk_fsm;
    logic [1:0] st;
    logic [3:0] sp;
    logic [3:0] b1;
    logic [3:0] b2;
    logic [7:0] s1;
    logic [7:0] s2;
  } vec_t;

`ifdef MONEY_STAGGER_EN
  localparam logic [1:0] LiveSt = 2'd1;
  localparam logic [3:0] LiveSp = 4'b0001;
`else
  localparam logic [1:0] LiveSt = 2'd2;
  localparam logic [3:0] LiveSp = 4'b1111;
`endif

  logic        FrameClk;
  logic        Reset;
  logic        RoundStart;
  logic        RoundStop;
  logic [7:0]  P1CollectVec;
  logic [7:0]  P2CollectVec;
  logic        P1Deposit;
  logic        P2Deposit;
  logic [3:0]  SpawnEnable;
  logic [39:0] SpawnX;
  logic [11:0] Random;
  logic        P1Full;
  logic        P2Full;
  logic [3:0]  P1Bag;
  logic [3:0]  P2Bag;
  logic [7:0]  P1Score;
  logic [7:0]  P2Score;
  logic [1:0]  RoundState;

  int          n_tests;
  int          n_fail;
  logic [15:0] lfsr_m;
  vec_t        sb_q[$];
  vec_t        tbl[16];

  money_scheduler dut (
    .FrameClk     (FrameClk),
    .Reset        (Reset),
    .RoundStart   (RoundStart),
    .RoundStop    (RoundStop),
    .P1CollectVec (P1CollectVec),
    .P2CollectVec (P2CollectVec),
    .P1Deposit    (P1Deposit),
    .P2Deposit    (P2Deposit),
    .SpawnEnable  (SpawnEnable),
    .SpawnX       (SpawnX),
    .Random       (Random),
    .P1Full       (P1Full),
    .P2Full       (P2Full),
    .P1Bag        (P1Bag),
    .P2Bag        (P2Bag),
    .P1Score      (P1Score),
    .P2Score      (P2Score),
    .RoundState   (RoundState)
  );

  initial FrameClk = 1'b0;
  always #5 FrameClk = ~FrameClk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic vec_t mk(input logic start, input logic stop, input logic [7:0] p1c,
                              input logic [7:0] p2c, input logic p1d, input logic p2d,
                              input logic chk, input logic [1:0] st, input logic [3:0] sp,
                              input logic [3:0] b1, input logic [3:0] b2,
                              input logic [7:0] s1, input logic [7:0] s2);
    vec_t v;
    v.start = start; v.stop = stop; v.p1c = p1c; v.p2c = p2c; v.p1d = p1d; v.p2d = p2d;
    v.chk_fsm = chk; v.st = st; v.sp = sp; v.b1 = b1; v.b2 = b2; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One frame: drive at the falling edge, check just after the next rising edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge FrameClk);
    RoundStart   = v.start;
    RoundStop    = v.stop;
    P1CollectVec = v.p1c;
    P2CollectVec = v.p2c;
    P1Deposit    = v.p1d;
    P2Deposit    = v.p2d;
    sb_q.push_back(v);
    @(posedge FrameClk);
    #1;
    RoundStart   = 1'b0;
    RoundStop    = 1'b0;
    P1CollectVec = 8'h00;
    P2CollectVec = 8'h00;
    P1Deposit    = 1'b0;
    P2Deposit    = 1'b0;
    lfsr_m = lfsr_next(lfsr_m);
    e = sb_q.pop_front();
    if (e.chk_fsm) begin
      check("round_state", 32'(RoundState), 32'(e.st));
      check("spawn_enable", 32'(SpawnEnable), 32'(e.sp));
    end
    check("p1_bag", 32'(P1Bag), 32'(e.b1));
    check("p2_bag", 32'(P2Bag), 32'(e.b2));
    check("p1_score", 32'(P1Score), 32'(e.s1));
    check("p2_score", 32'(P2Score), 32'(e.s2));
    check("p1_full", 32'(P1Full), 32'(e.b1 >= 4'd6));
    check("p2_full", 32'(P2Full), 32'(e.b2 >= 4'd6));
    check("random", 32'(Random), 32'(lfsr_m[11:0]));
  endtask

  initial begin
    logic [3:0] sp;
    n_tests      = 0;
    n_fail       = 0;
    lfsr_m       = 16'hACE1;
    Reset        = 1'b1;
    RoundStart   = 1'b0;
    RoundStop    = 1'b0;
    P1CollectVec = 8'h00;
    P2CollectVec = 8'h00;
    P1Deposit    = 1'b0;
    P2Deposit    = 1'b0;

    //          start stop p1c    p2c    p1d p2d chk st     sp     b1 b2 s1 s2
    tbl[0]  = mk(0, 0, 8'h03, 8'h00, 0, 0, 1, 2'd0,  4'h0,   0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 8'h00, 0, 0, 1, LiveSt, LiveSp, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 8'h09, 8'h20, 0, 0, 1, LiveSt, LiveSp, 3, 2, 0, 0);
    tbl[3]  = mk(0, 0, 8'h40, 8'h00, 0, 0, 1, LiveSt, LiveSp, 4, 2, 0, 0);
    tbl[4]  = mk(0, 0, 8'hC8, 8'h03, 0, 0, 1, LiveSt, LiveSp, 6, 5, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 8'h00, 0, 1, 1, LiveSt, LiveSp, 6, 0, 0, 5);
    tbl[6]  = mk(0, 0, 8'h10, 8'h0B, 0, 0, 1, LiveSt, LiveSp, 6, 5, 0, 5);
    tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 1, LiveSt, LiveSp, 0, 0, 6, 10);
    tbl[8]  = mk(0, 0, 8'h00, 8'h0B, 0, 0, 1, LiveSt, LiveSp, 0, 5, 6, 10);
    tbl[9]  = mk(0, 0, 8'h00, 8'h01, 0, 1, 1, LiveSt, LiveSp, 0, 1, 6, 15);
    tbl[10] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 1, LiveSt, LiveSp, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 8'h02, 8'h00, 0, 0, 1, LiveSt, LiveSp, 2, 0, 0, 0);
    tbl[12] = mk(0, 1, 8'h03, 8'h00, 0, 1, 1, 2'd3,  4'h0,   2, 0, 0, 0);
    tbl[13] = mk(0, 1, 8'h03, 8'h00, 0, 0, 1, 2'd3,  4'h0,   2, 0, 0, 0);
    tbl[14] = mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 2'd3,  4'h0,   2, 0, 0, 0);
    tbl[15] = mk(1, 0, 8'h00, 8'h00, 0, 0, 1, LiveSt, LiveSp, 0, 0, 0, 0);

    // Reset values
    #1;
    check("rst_state", 32'(RoundState), 32'd0);
    check("rst_spawn", 32'(SpawnEnable), 32'd0);
    check("rst_bags", 32'({P1Bag, P2Bag}), 32'd0);
    check("rst_scores", 32'({P1Score, P2Score}), 32'd0);
    check("rst_full", 32'({P1Full, P2Full}), 32'd0);
    check("rst_random", 32'(Random), 32'h0CE1);
    check("spawn_x0", 32'(SpawnX[9:0]), 32'd40);
    check("spawn_x1", 32'(SpawnX[19:10]), 32'd180);
    check("spawn_x2", 32'(SpawnX[29:20]), 32'd320);
    check("spawn_x3", 32'(SpawnX[39:30]), 32'd460);
    @(posedge FrameClk);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Score saturation: 42 full bags bank 252, one more saturates at 255.
    for (int i = 0; i < 42; i++) begin
      step(mk(0, 0, 8'hFF, 8'h00, 0, 0, 0, 2'd0, 4'h0, 6, 0, 8'(6 * i), 0));
      step(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 2'd0, 4'h0, 0, 0, 8'(6 * (i + 1)), 0));
    end
    step(mk(0, 0, 8'hFF, 8'h00, 0, 0, 0, 2'd0, 4'h0, 6, 0, 252, 0));
    step(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 2'd0, 4'h0, 0, 0, 255, 0));

`ifdef MONEY_STAGGER_EN
    // Stagger: RoundStart in frame 0, enables at frames 1/31/61/91, ACTIVE from 91.
    step(mk(1, 0, 8'h00, 8'h00, 0, 0, 1, 2'd1, 4'b0001, 0, 0, 0, 0));
    for (int f = 2; f <= 92; f++) begin
      sp = 4'h0;
      for (int k = 0; k < 4; k++) if (f - 1 >= 30 * k) sp[k] = 1'b1;
      step(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, (f >= 91) ? 2'd2 : 2'd1, sp, 0, 0, 0, 0));
    end
`else
    step(mk(1, 0, 8'h00, 8'h00, 0, 0, 1, 2'd2, 4'hF, 0, 0, 0, 0));
    for (int f = 0; f < 3; f++) step(mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 2'd2, 4'hF, 0, 0, 0, 0));
`endif

    // Reset mid-round with a nonzero bag; effect must be visible before any clock edge.
    step(mk(0, 0, 8'h05, 8'h00, 0, 0, 1, 2'd2, 4'hF, 2, 0, 0, 0));
    Reset = 1'b1;
    #1;
    lfsr_m = 16'hACE1;
    check("midrst_state", 32'(RoundState), 32'd0);
    check("midrst_spawn", 32'(SpawnEnable), 32'd0);
    check("midrst_bag", 32'(P1Bag), 32'd0);
    check("midrst_full", 32'(P1Full), 32'd0);
    check("midrst_random", 32'(Random), 32'(lfsr_m[11:0]));
    #1;
    Reset = 1'b0;
    step(mk(1, 0, 8'h00, 8'h00, 0, 0, 1, LiveSt, LiveSp, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
